// File: rtl/updown_step_counter.sv
// Registered up/down counter with programmable step, built on a ripple chain of full-adder cells.
// Define UPDOWN_STEP_SAT_EN to clamp on overflow/underflow instead of wrapping modulo 2^WIDTH.

module updown_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end
endmodule

module updown_step_counter #(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             ca_out,
    output logic             zero
);
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    logic             flag;
    logic [WIDTH-1:0] next_count;

    // Down-count adds ~step with carry-in 1; the final carry is then inverted to give borrow.
    always_comb begin
        operand  = dir ? step : ~step;
        carry[0] = ~dir;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        updown_full_adder u_fa (
            .a    (count[i]),
            .b    (operand[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        flag = dir ? carry[WIDTH] : ~carry[WIDTH];
`ifdef UPDOWN_STEP_SAT_EN
        if (flag)
            next_count = dir ? '1 : '0;
        else
            next_count = sum;
`else
        next_count = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= RESET_VAL;
            ca_out <= 1'b0;
        end else if (load) begin
            count  <= load_val;
            ca_out <= 1'b0;
        end else if (en) begin
            count  <= next_count;
            ca_out <= flag;
        end else begin
            ca_out <= 1'b0;
        end
    end

    assign zero = (count == '0);

endmodule

// File: tb/tb_updown_step_counter.sv
// Scoreboard bench: the driver pushes expected count/ca_out per issued cycle, the monitor pops and compares.
// Directed vectors, then randomised traffic checked against a reference model; honours UPDOWN_STEP_SAT_EN.

module tb_updown_step_counter;
    localparam int unsigned W = 4;
`ifdef UPDOWN_STEP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         dir = 1'b0;
    logic [W-1:0] step = '0;
    logic [W-1:0] count;
    logic         ca_out;
    logic         zero;

    typedef struct {
        logic [W-1:0] cnt;
        logic         ca;
        int           id;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] m_count;

    updown_step_counter #(.WIDTH(W), .RESET_VAL(4'd9)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .step     (step),
        .count    (count),
        .ca_out   (ca_out),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle with a pending expectation is compared 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (count !== e.cnt) begin
                failures++;
                $display("FAIL count vec=%0d got=%0d expected=%0d", e.id, count, e.cnt);
            end
            checks++;
            if (ca_out !== e.ca) begin
                failures++;
                $display("FAIL ca_out vec=%0d got=%b expected=%b", e.id, ca_out, e.ca);
            end
            checks++;
            if (zero !== (e.cnt == '0)) begin
                failures++;
                $display("FAIL zero vec=%0d got=%b expected=%b", e.id, zero, (e.cnt == '0));
            end
        end
    end

    task automatic issue(input logic r, input logic l, input logic [W-1:0] lv,
                         input logic e, input logic d, input logic [W-1:0] s,
                         input logic [W-1:0] ec, input logic eca, input int id);
        exp_t x;
        @(negedge clk);
        rst = r; load = l; load_val = lv; en = e; dir = d; step = s;
        x.cnt = ec; x.ca = eca; x.id = id;
        sb.push_back(x);
        m_count = ec;
    endtask

    task automatic model(input logic r, input logic l, input logic [W-1:0] lv,
                         input logic e, input logic d, input logic [W-1:0] s,
                         output logic [W-1:0] nc, output logic nca);
        int t;
        nc = m_count; nca = 1'b0;
        if (r) begin
            nc = 4'd9;
        end else if (l) begin
            nc = lv;
        end else if (e) begin
            if (d) begin
                t   = int'(m_count) + int'(s);
                nca = (t > 15);
                nc  = (nca && SAT) ? 4'd15 : 4'(t);
            end else begin
                t   = int'(m_count) - int'(s);
                nca = (t < 0);
                nc  = (nca && SAT) ? 4'd0 : 4'(t);
            end
        end
    endtask

    initial begin
        logic [W-1:0] nc, lv, s;
        logic         nca, r, l, e, d;

        // reset wins over load and en
        issue(1, 1, 4'd5, 1, 1, 4'd2, 4'd9, 0, 1);
        // load wins over en
        issue(0, 1, 4'd3, 1, 1, 4'd2, 4'd3, 0, 2);
        // count down by 1 through zero
        issue(0, 0, 4'd0, 1, 0, 4'd1, 4'd2, 0, 3);
        issue(0, 0, 4'd0, 1, 0, 4'd1, 4'd1, 0, 4);
        issue(0, 0, 4'd0, 1, 0, 4'd1, 4'd0, 0, 5);
        issue(0, 0, 4'd0, 1, 0, 4'd1, SAT ? 4'd0 : 4'd15, 1, 6);
        // 14 + 5 overflow, then hold
        issue(0, 1, 4'd14, 0, 0, 4'd0, 4'd14, 0, 7);
        issue(0, 0, 4'd0, 1, 1, 4'd5, SAT ? 4'd15 : 4'd3, 1, 8);
        issue(0, 0, 4'd0, 0, 1, 4'd5, SAT ? 4'd15 : 4'd3, 0, 9);
        // 0 - 15 borrow
        issue(0, 1, 4'd0, 0, 0, 4'd0, 4'd0, 0, 10);
        issue(0, 0, 4'd0, 1, 0, 4'd15, SAT ? 4'd0 : 4'd1, 1, 11);
        // 2 - 7 borrow
        issue(0, 1, 4'd2, 0, 0, 4'd0, 4'd2, 0, 12);
        issue(0, 0, 4'd0, 1, 0, 4'd7, SAT ? 4'd0 : 4'd11, 1, 13);
        // step 0 in both directions holds
        issue(0, 0, 4'd0, 1, 1, 4'd0, SAT ? 4'd0 : 4'd11, 0, 14);
        issue(0, 0, 4'd0, 1, 0, 4'd0, SAT ? 4'd0 : 4'd11, 0, 15);
        // 15 + 1
        issue(0, 1, 4'd15, 0, 0, 4'd0, 4'd15, 0, 16);
        issue(0, 0, 4'd0, 1, 1, 4'd1, SAT ? 4'd15 : 4'd0, 1, 17);
        // non-overflowing up, then mid-sequence reset
        issue(0, 1, 4'd4, 0, 0, 4'd0, 4'd4, 0, 18);
        issue(0, 0, 4'd0, 1, 1, 4'd6, 4'd10, 0, 19);
        issue(1, 0, 4'd0, 1, 1, 4'd6, 4'd9, 0, 20);

        for (int i = 0; i < 10000; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 9) == 0);
            lv = 4'($urandom);
            e  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom);
            s  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            model(r, l, lv, e, d, s, nc, nca);
            issue(r, l, lv, e, d, s, nc, nca, 1000 + i);
        end

        @(negedge clk);
        en = 1'b0; load = 1'b0; rst = 1'b0;
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
